// File: rtl/mine_placer_pkg.sv
// Shared minesweeper definitions.
// Purpose: board geometry constants used by the mine placer, the board
// bitmap RAM and the game FSM, plus the state encoding of the mine placer.
// Ports: none (package).
package mine_placer_pkg;

  // Default board geometry; the board RAM and game FSM size themselves
  // from the same numbers so every block agrees on the cell index width.
  localparam int BOARD_ROWS    = 16;
  localparam int BOARD_COLS    = 16;
  localparam int BOARD_CELLS   = BOARD_ROWS * BOARD_COLS;
  localparam int BOARD_IDX_W   = $clog2(BOARD_CELLS);
  localparam int DEF_MINES     = 40;
  localparam int DEF_MAX_TRIES = 4096;

  // Mine placer sequencing states.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CLEAR  = 3'd1,
    ST_SAMPLE = 3'd2,
    ST_RD     = 3'd3,
    ST_CHK    = 3'd4,
    ST_WR     = 3'd5,
    ST_DONE   = 3'd6
  } placer_state_t;

endpackage

// File: rtl/mine_placer.sv
// Mine placer: clears the board bitmap, then places MINES mines at
// pseudo-random cells by rejection sampling of an external LFSR stream.
// Ports:
//   clk, rst      clock and synchronous active-high reset
//   start         begin a new board (only honoured while idle)
//   safe_cell     first-click cell that must stay mine-free
//   rnd           candidate cell index, new value every clock
//   mem_addr/mem_we/mem_wdata/mem_rdata  single-port bitmap RAM interface
//   busy          generation in progress
//   done          one-cycle pulse when all mines are placed
//   err           sticky abort flag (too many rejections)
//   placed        number of mines placed so far
module mine_placer
  import mine_placer_pkg::*;
#(
  parameter  int ROWS      = BOARD_ROWS,
  parameter  int COLS      = BOARD_COLS,
  parameter  int MINES     = DEF_MINES,
  parameter  int MAX_TRIES = DEF_MAX_TRIES,
  localparam int CELLS     = ROWS * COLS,
  localparam int IDX_W     = $clog2(CELLS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [IDX_W-1:0] safe_cell,
  input  logic [IDX_W-1:0] rnd,
  output logic [IDX_W-1:0] mem_addr,
  output logic             mem_we,
  output logic             mem_wdata,
  input  logic             mem_rdata,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [IDX_W-1:0] placed
);

  localparam int TRY_W = $clog2(MAX_TRIES + 1);

  // A board must leave room for the protected first-click cell.
  if (MINES > CELLS - 1) begin : g_mines_check
    $error("mine_placer: MINES must not exceed ROWS*COLS-1");
  end

  placer_state_t    state, state_n;
  logic [IDX_W-1:0] safe_q;
  logic [IDX_W-1:0] cand_q;
  logic [IDX_W-1:0] clr_idx;
  logic [TRY_W-1:0] tries;
  logic [TRY_W-1:0] tries_inc;
  logic [31:0]      rnd_ext;
  logic             reject_rnd;
  logic             last_try;

  // Candidate screening. rnd is widened so the range test still works when
  // CELLS is a power of two and no index can actually be out of range.
  assign rnd_ext    = {{(32-IDX_W){1'b0}}, rnd};
  assign reject_rnd = (rnd_ext >= 32'(CELLS)) || (rnd == safe_q);
  assign last_try   = (tries == TRY_W'(MAX_TRIES - 1));
  assign tries_inc  = (tries == TRY_W'(MAX_TRIES)) ? tries : tries + 1'b1;

  // State register and datapath registers: latch the safe cell on an
  // accepted start, walk the clear index, capture candidates, count
  // rejections (saturating) and placed mines, and raise err on abort.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      safe_q  <= '0;
      cand_q  <= '0;
      clr_idx <= '0;
      tries   <= '0;
      placed  <= '0;
      err     <= 1'b0;
    end else begin
      state <= state_n;
      case (state)
        ST_IDLE: begin
          if (start) begin
            safe_q  <= safe_cell;
            err     <= 1'b0;
            placed  <= '0;
            tries   <= '0;
            clr_idx <= '0;
          end
        end
        ST_CLEAR: begin
          if (clr_idx != IDX_W'(CELLS - 1)) begin
            clr_idx <= clr_idx + 1'b1;
          end
        end
        ST_SAMPLE: begin
          cand_q <= rnd;
          if (reject_rnd) begin
            tries <= tries_inc;
            if (last_try) begin
              err <= 1'b1;
            end
          end
        end
        ST_CHK: begin
          if (mem_rdata) begin
            tries <= tries_inc;
            if (last_try) begin
              err <= 1'b1;
            end
          end
        end
        ST_WR: begin
          placed <= placed + 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  // Next-state decode. Every rejection path leaves for IDLE instead of
  // SAMPLE once the rejection budget is exhausted.
  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE:   if (start) state_n = ST_CLEAR;
      ST_CLEAR:  if (clr_idx == IDX_W'(CELLS - 1)) state_n = ST_SAMPLE;
      ST_SAMPLE: begin
        if (reject_rnd) state_n = last_try ? ST_IDLE : ST_SAMPLE;
        else            state_n = ST_RD;
      end
      ST_RD:     state_n = ST_CHK;
      ST_CHK: begin
        if (mem_rdata) state_n = last_try ? ST_IDLE : ST_SAMPLE;
        else           state_n = ST_WR;
      end
      ST_WR:     state_n = (placed == IDX_W'(MINES - 1)) ? ST_DONE : ST_SAMPLE;
      ST_DONE:   state_n = ST_IDLE;
      default:   state_n = ST_IDLE;
    endcase
  end

  // RAM-side and status outputs are decoded only from the state and
  // registered indices, so rnd never reaches the RAM combinationally.
  always_comb begin
    mem_we    = (state == ST_CLEAR) || (state == ST_WR);
    mem_wdata = (state == ST_WR);
    mem_addr  = '0;
    if (state == ST_CLEAR) begin
      mem_addr = clr_idx;
    end else if ((state == ST_RD) || (state == ST_WR)) begin
      mem_addr = cand_q;
    end
    busy = (state != ST_IDLE) && (state != ST_DONE);
    done = (state == ST_DONE);
  end

endmodule

// File: tb/tb_mine_placer.sv
// Testbench for mine_placer.
// Purpose: drives directed and randomised candidate streams into a 4x4
// board instance (plus a 3x5 instance for the range check), models the
// bitmap RAM, and compares against a rule-level model of the placement.
// Ports: none (top-level bench).
module tb_mine_placer;

  localparam int CELLS     = 16;
  localparam int IDX_W     = 4;
  localparam int MINES     = 3;
  localparam int MAX_TRIES = 8;
  localparam int MAXC      = 256;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [IDX_W-1:0] safe_cell = '0;
  logic [IDX_W-1:0] rnd = '0;
  logic [IDX_W-1:0] mem_addr;
  logic             mem_we;
  logic             mem_wdata;
  logic             mem_rdata = 1'b0;
  logic             busy;
  logic             done;
  logic             err;
  logic [IDX_W-1:0] placed;

  logic             start2 = 1'b0;
  logic [3:0]       safe2 = '0;
  logic [3:0]       rnd2 = '0;
  logic [3:0]       mem_addr2;
  logic             mem_we2;
  logic             mem_wdata2;
  logic             mem_rdata2 = 1'b0;
  logic             busy2;
  logic             done2;
  logic             err2;
  logic [3:0]       placed2;

  int checks = 0;
  int failures = 0;

  logic [IDX_W-1:0] stream [MAXC];
  logic [15:0]      ram_bits = 16'hFFFF;

  int          exp_done_cycle;
  logic        exp_err;
  int          exp_placed;
  logic [15:0] exp_mask;

  int   obs_done_cycle;
  int   obs_done_cnt;
  int   obs_ones;
  int   obs_zeros;
  int   obs_end;
  logic obs_clear_ok;
  logic obs_busy1;

  mine_placer #(.ROWS(4), .COLS(4), .MINES(MINES), .MAX_TRIES(MAX_TRIES)) dut (
    .clk(clk), .rst(rst), .start(start), .safe_cell(safe_cell), .rnd(rnd),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy), .done(done), .err(err),
    .placed(placed)
  );

  mine_placer #(.ROWS(3), .COLS(5), .MINES(MINES), .MAX_TRIES(MAX_TRIES)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .safe_cell(safe2), .rnd(rnd2),
    .mem_addr(mem_addr2), .mem_we(mem_we2), .mem_wdata(mem_wdata2),
    .mem_rdata(mem_rdata2), .busy(busy2), .done(done2), .err(err2),
    .placed(placed2)
  );

  // Free-running clock, 10 time units per cycle.
  always #5 clk = ~clk;

  // Single-port bitmap RAM with one-cycle registered read.
  always @(posedge clk) begin
    if (mem_we) ram_bits[mem_addr] <= mem_wdata;
    mem_rdata <= ram_bits[mem_addr];
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Rule-level model: cycle 0 is the start cycle, CELLS clear cycles
  // follow, then each candidate costs 1 cycle if out of range or safe,
  // 3 cycles if already mined, 4 cycles if placed.
  task automatic runModel(input logic [IDX_W-1:0] safe);
    int t;
    int tries;
    int c;
    bit abort;
    t = CELLS + 1;
    tries = 0;
    abort = 0;
    exp_mask = '0;
    exp_placed = 0;
    while (exp_placed < MINES && !abort) begin
      c = int'(stream[t]);
      if (c >= CELLS || c == int'(safe)) begin
        tries++;
        t += 1;
      end else if (exp_mask[c]) begin
        tries++;
        t += 3;
      end else begin
        exp_mask[c] = 1'b1;
        exp_placed++;
        t += 4;
      end
      if (tries == MAX_TRIES) abort = 1;
    end
    exp_err = abort;
    exp_done_cycle = abort ? -1 : t;
  endtask

  task automatic fillSeg(input int first, input int len, input logic [IDX_W-1:0] v);
    for (int i = first; i < first + len; i++) stream[i] = v;
  endtask

  // One full generation: stream[k] is presented during cycle k after start.
  task automatic applyStimulus(input logic [IDX_W-1:0] safe, input int pulse_at);
    runModel(safe);
    @(negedge clk);
    start = 1'b1;
    safe_cell = safe;
    rnd = stream[0];
    obs_done_cycle = -1;
    obs_done_cnt = 0;
    obs_ones = 0;
    obs_zeros = 0;
    obs_end = -1;
    obs_clear_ok = 1'b1;
    obs_busy1 = 1'b0;
    for (int k = 1; k < 200; k++) begin
      @(posedge clk);
      #1;
      start = (k == pulse_at);
      rnd = stream[k];
      if (done === 1'b1) begin
        obs_done_cnt++;
        if (obs_done_cycle < 0) obs_done_cycle = k;
      end
      if (k <= CELLS) begin
        if (!(mem_we === 1'b1 && mem_wdata === 1'b0 && mem_addr === IDX_W'(k - 1)))
          obs_clear_ok = 1'b0;
      end
      if (mem_we === 1'b1) begin
        if (mem_wdata === 1'b1) obs_ones++;
        else obs_zeros++;
      end
      if (k == 1) obs_busy1 = busy;
      if (k > CELLS && busy === 1'b0 && done === 1'b0) begin
        obs_end = k;
        break;
      end
    end
    start = 1'b0;
    checkOutput("timeout", 32'(obs_end < 0), 0);
    checkOutput("busy_after_start", 32'(obs_busy1), 1);
    checkOutput("clear_sequence", 32'(obs_clear_ok), 1);
    checkOutput("zero_writes", obs_zeros, CELLS);
    checkOutput("one_writes", obs_ones, exp_placed);
    checkOutput("done_count", obs_done_cnt, exp_err ? 0 : 1);
    checkOutput("done_cycle", obs_done_cycle, exp_done_cycle);
    checkOutput("err", 32'(err), 32'(exp_err));
    checkOutput("placed", 32'(placed), exp_placed);
    checkOutput("ram_mask", 32'(ram_bits), 32'(exp_mask));
  endtask

  initial begin
    int idle_we;
    int end2;
    int we2_cnt;
    logic [IDX_W-1:0] rs;

    // Reset and idle behaviour.
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_outputs", 32'({busy, done, err, mem_we, mem_wdata, mem_addr, placed}), 0);
    checkOutput("reset_outputs2", 32'({busy2, done2, err2, mem_we2, mem_wdata2, mem_addr2, placed2}), 0);
    rst = 1'b0;
    idle_we = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (mem_we !== 1'b0 || busy !== 1'b0) idle_we++;
    end
    checkOutput("idle_quiet", idle_we, 0);

    // Directed rejections: 5 (safe), 3 placed, 3 already mined, 9, 12.
    fillSeg(0, MAXC, 4'd5);
    fillSeg(CELLS + 1, 1, 4'd5);
    fillSeg(CELLS + 2, 4, 4'd3);
    fillSeg(CELLS + 6, 3, 4'd3);
    fillSeg(CELLS + 9, 4, 4'd9);
    fillSeg(CELLS + 13, 4, 4'd12);
    applyStimulus(4'd5, 0);
    checkOutput("directed_done_cycle", obs_done_cycle, 33);
    checkOutput("directed_mask", 32'(ram_bits), 32'h1208);
    checkOutput("directed_placed", 32'(placed), 3);

    // Minimum latency, with a start pulse during CLEAR that must be ignored.
    fillSeg(0, MAXC, 4'd5);
    fillSeg(CELLS + 1, 4, 4'd1);
    fillSeg(CELLS + 5, 4, 4'd2);
    fillSeg(CELLS + 9, 4, 4'd7);
    applyStimulus(4'd5, 5);
    checkOutput("min_latency", obs_done_cycle, CELLS + 4 * MINES + 1);

    // Abort: only the safe cell is ever offered.
    fillSeg(0, MAXC, 4'd5);
    applyStimulus(4'd5, 0);
    checkOutput("abort_busy", 32'(busy), 0);

    // Next start clears err; then a reset during SAMPLE aborts at once.
    @(negedge clk);
    start = 1'b1;
    safe_cell = 4'd5;
    rnd = 4'd5;
    @(posedge clk);
    #1;
    start = 1'b0;
    checkOutput("err_cleared", 32'(err), 0);
    checkOutput("busy_restart", 32'(busy), 1);
    repeat (CELLS + 2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("midrun_reset", 32'({busy, done, err, mem_we, mem_wdata, mem_addr, placed}), 0);

    // Range check on the 15-cell board: index 15 never touches the RAM.
    @(negedge clk);
    start2 = 1'b1;
    safe2 = 4'd0;
    rnd2 = 4'd15;
    end2 = -1;
    we2_cnt = 0;
    for (int k = 1; k < 60; k++) begin
      @(posedge clk);
      #1;
      start2 = 1'b0;
      if (k > 15 && mem_we2 === 1'b1) we2_cnt++;
      if (k > 15 && busy2 === 1'b0) begin
        end2 = k;
        break;
      end
    end
    checkOutput("range_end_cycle", end2, 24);
    checkOutput("range_no_write", we2_cnt, 0);
    checkOutput("range_err", 32'(err2), 1);
    checkOutput("range_placed", 32'(placed2), 0);

    // Randomised candidate streams against the rule-level model.
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < MAXC; i++) stream[i] = IDX_W'($urandom_range(0, CELLS - 1));
      rs = IDX_W'($urandom_range(0, CELLS - 1));
      applyStimulus(rs, 0);
      checkOutput("random_safe_free", 32'(ram_bits[rs]), 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
